// File: rtl/mux_pkg.sv
// Shared types and constants for the two-source burst arbiter.
package mux_pkg;
  localparam int WIDTH_DEF = 8;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_t;
endpackage

// File: rtl/mux_arb_mux2.sv
// Single-bit 2:1 mux, Z = ~S ? A : B.
module mux_arb_mux2 (
  input  logic a_i,
  input  logic b_i,
  input  logic s_i,
  output logic z_o
);
  assign z_o = ~s_i ? a_i : b_i;
endmodule

// File: rtl/mux_arb.sv
// Two-source burst arbiter: round-robin on ties, locks onto a source until its
// last beat, and feeds one registered output stage.
module mux_arb
  import mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             s,
  output logic             z_valid,
  output logic [WIDTH-1:0] z_data,
  output logic             z_src,
  input  logic             z_ready
);

  arb_state_t       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             z_valid_q, z_valid_d;
  logic [WIDTH-1:0] z_data_q, z_data_d;
  logic             z_src_q, z_src_d;

  logic             s_sel;
  logic             load;
  logic             xfer;
  logic             xfer_last;
  logic [WIDTH-1:0] mux_z;

  // Grant select; reset forces B so the reset-time view is fixed regardless of inputs.
  always_comb begin
    s_sel = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (a_valid && !b_valid)      s_sel = SEL_A;
        else if (!a_valid && b_valid) s_sel = SEL_B;
        else if (a_valid && b_valid)  s_sel = ~last_grant_q;
        else                          s_sel = last_grant_q;
      end
      LOCK_A:  s_sel = SEL_A;
      LOCK_B:  s_sel = SEL_B;
      default: s_sel = last_grant_q;
    endcase
    if (!rst_n) s_sel = SEL_B;
  end

  assign load      = !z_valid_q || z_ready;
  assign a_ready   = rst_n && load && a_valid && (s_sel == SEL_A);
  assign b_ready   = rst_n && load && b_valid && (s_sel == SEL_B);
  assign xfer      = a_ready || b_ready;
  assign xfer_last = (s_sel == SEL_B) ? b_last : a_last;
  assign s         = s_sel;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_mux
      mux_arb_mux2 u_mux (
        .a_i (a_data[gi]),
        .b_i (b_data[gi]),
        .s_i (s_sel),
        .z_o (mux_z[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          last_grant_d = s_sel;
          if (!xfer_last) state_d = (s_sel == SEL_B) ? LOCK_B : LOCK_A;
        end
      end
      LOCK_A, LOCK_B: begin
        if (xfer && xfer_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage: refills in the same cycle it drains, so bursts stream without bubbles.
  always_comb begin
    z_valid_d = z_valid_q;
    z_data_d  = z_data_q;
    z_src_d   = z_src_q;
    if (load) begin
      z_valid_d = xfer;
      if (xfer) begin
        z_data_d = mux_z;
        z_src_d  = s_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      z_valid_q    <= 1'b0;
      z_data_q     <= '0;
      z_src_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      z_valid_q    <= z_valid_d;
      z_data_q     <= z_data_d;
      z_src_q      <= z_src_d;
    end
  end

  assign z_valid = z_valid_q;
  assign z_data  = z_data_q;
  assign z_src   = z_src_q;

endmodule

// File: tb/tb_mux_arb.sv
// Bench for mux_arb: directed vector table, reset-mid-burst sequence, random scoreboard.
module tb_mux_arb;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         a_valid, a_last, a_ready;
  logic [W-1:0] a_data;
  logic         b_valid, b_last, b_ready;
  logic [W-1:0] b_data;
  logic         s, z_valid, z_src, z_ready;
  logic [W-1:0] z_data;

  int n_cmp = 0;
  int n_err = 0;

  mux_arb #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .s(s), .z_valid(z_valid), .z_data(z_data), .z_src(z_src), .z_ready(z_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         av; logic [W-1:0] ad; logic al;
    logic         bv; logic [W-1:0] bd; logic bl;
    logic         zr;
    logic         es; logic ear; logic ebr;
    logic         ezv; logic [W-1:0] ezd; logic ezs;
  } vec_t;

  typedef struct packed {
    logic         src;
    logic [W-1:0] data;
  } beat_t;

  vec_t  vecs [18];
  beat_t sb_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drv(input logic av, input logic [W-1:0] ad, input logic al,
                     input logic bv, input logic [W-1:0] bd, input logic bl,
                     input logic zr);
    a_valid = av; a_data = ad; a_last = al;
    b_valid = bv; b_data = bd; b_last = bl;
    z_ready = zr;
  endtask

  initial begin
    beat_t hd;
    logic  acc_a, acc_b, own_v, own_src;
    int    cnt_a, cnt_b;

    // av ad al  bv bd bl  zr | s ar br  zv zd zs
    vecs[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0};
    vecs[2]  = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1};
    vecs[3]  = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0};
    vecs[4]  = '{1'b1, 8'hA0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1};
    vecs[5]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0};
    vecs[6]  = '{1'b1, 8'hA2, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 1'b0};
    vecs[8]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1};
    vecs[9]  = '{1'b1, 8'h5B, 1'b1, 1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0};
    vecs[10] = '{1'b1, 8'h5B, 1'b1, 1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0};
    vecs[11] = '{1'b1, 8'h5B, 1'b1, 1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0};
    vecs[12] = '{1'b1, 8'h5B, 1'b1, 1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0};
    vecs[13] = '{1'b1, 8'h5B, 1'b1, 1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0};
    vecs[14] = '{1'b1, 8'h5B, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h66, 1'b1};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5B, 1'b0};
    vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b1};
    vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

    // Reset with both sources offering: nothing may be accepted.
    rst_n = 1'b0;
    drv(1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
    #12;
    chk("rst_z_valid", 32'(z_valid), 32'd0);
    chk("rst_z_data",  32'(z_data),  32'd0);
    chk("rst_z_src",   32'(z_src),   32'd0);
    chk("rst_s",       32'(s),       32'd1);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    drv(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) begin
      drv(vecs[i].av, vecs[i].ad, vecs[i].al, vecs[i].bv, vecs[i].bd, vecs[i].bl, vecs[i].zr);
      @(negedge clk);
      chk($sformatf("v%0d_s", i),       32'(s),       32'(vecs[i].es));
      chk($sformatf("v%0d_a_ready", i), 32'(a_ready), 32'(vecs[i].ear));
      chk($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(vecs[i].ebr));
      chk($sformatf("v%0d_z_valid", i), 32'(z_valid), 32'(vecs[i].ezv));
      if (vecs[i].ezv) begin
        chk($sformatf("v%0d_z_data", i), 32'(z_data), 32'(vecs[i].ezd));
        chk($sformatf("v%0d_z_src", i),  32'(z_src),  32'(vecs[i].ezs));
      end
      @(posedge clk); #1;
    end

    // Reset in the middle of a B burst.
    drv(1'b0, 8'h00, 1'b0, 1'b1, 8'hB0, 1'b0, 1'b1);
    @(posedge clk); #1;
    drv(1'b0, 8'h00, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("burst_b1_data", 32'(z_data), 32'hB1);
    drv(1'b1, 8'h33, 1'b1, 1'b1, 8'hB2, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_z_valid", 32'(z_valid), 32'd0);
    chk("mid_rst_z_data",  32'(z_data),  32'd0);
    chk("mid_rst_s",       32'(s),       32'd1);
    chk("mid_rst_a_ready", 32'(a_ready), 32'd0);
    chk("mid_rst_b_ready", 32'(b_ready), 32'd0);
    @(posedge clk); #1;
    chk("rst_edge_no_xfer", 32'(z_valid), 32'd0);
    drv(1'b1, 8'h33, 1'b1, 1'b1, 8'h44, 1'b1, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("post_rst_tie_s",       32'(s),       32'd0);
    chk("post_rst_tie_a_ready", 32'(a_ready), 32'd1);
    chk("post_rst_tie_b_ready", 32'(b_ready), 32'd0);
    @(posedge clk); #1;
    chk("post_rst_z_valid", 32'(z_valid), 32'd1);
    chk("post_rst_z_data",  32'(z_data),  32'h33);
    chk("post_rst_z_src",   32'(z_src),   32'd0);
    drv(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("drain_z_valid", 32'(z_valid), 32'd0);

    // Random traffic against a one-deep output scoreboard.
    acc_a = 1'b0; acc_b = 1'b0; own_v = 1'b0; own_src = 1'b0;
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 10000; c++) begin
      if (acc_a || !a_valid) begin
        a_valid = 1'($urandom_range(0, 1));
        a_data  = 8'($urandom);
        a_last  = ($urandom_range(0, 2) == 0);
      end
      if (acc_b || !b_valid) begin
        b_valid = 1'($urandom_range(0, 1));
        b_data  = 8'($urandom);
        b_last  = ($urandom_range(0, 2) == 0);
      end
      z_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (sb_q.size() != 0) begin
        hd = sb_q[0];
        chk("rnd_z_valid", 32'(z_valid), 32'd1);
        chk("rnd_z_data",  32'(z_data),  32'(hd.data));
        chk("rnd_z_src",   32'(z_src),   32'(hd.src));
      end else begin
        chk("rnd_z_empty", 32'(z_valid), 32'd0);
      end
      chk("rnd_one_ready", 32'(a_ready && b_ready), 32'd0);
      if (z_valid && !z_ready)
        chk("rnd_stall_ready", 32'(a_ready || b_ready), 32'd0);
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      if (z_valid && z_ready && sb_q.size() != 0) void'(sb_q.pop_front());
      if (acc_a || acc_b) begin
        if (own_v) chk("rnd_burst_owner", 32'(acc_b), 32'(own_src));
        own_v   = acc_b ? !b_last : !a_last;
        own_src = acc_b;
        sb_q.push_back('{src: acc_b, data: (acc_b ? b_data : a_data)});
        if (acc_a) cnt_a++; else cnt_b++;
      end
      @(posedge clk); #1;
    end
    chk("rnd_a_progress", 32'(cnt_a > 100), 32'd1);
    chk("rnd_b_progress", 32'(cnt_b > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
